spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_pkg.sv | 33 +++
 rtl/spi_clk_gen.sv | 27 ++
 rtl/spi_master_ctrl.sv | 145 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller states, mode bit encoding and frame sizing.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  // MODE is {CPOL, CPHA}
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  localparam int CPOL_BIT   = 1;
  localparam int CPHA_BIT   = 0;
  localparam int FRAME_BITS = 8;
  localparam int SCK_EDGES  = 2 * FRAME_BITS;

  function automatic logic cpol_of(input logic [1:0] mode);
    return mode[CPOL_BIT];
  endfunction

  function automatic logic cpha_of(input logic [1:0] mode);
    return mode[CPHA_BIT];
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled, held at zero otherwise.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == DIV_M1) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign tick = en && (cnt_q == DIV_M1);

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-byte SPI master: all four modes, SS framing with setup/hold/gap of one SCK half-period each.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [1:0] MODE,
  input  logic [7:0] TX_DATA,
  output logic [7:0] RX_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       SCK,
  output logic       SS,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [4:0] LAST_EDGE  = 5'(SCK_EDGES - 1);
  localparam logic [4:0] LAST_SHIFT = 5'(SCK_EDGES - 2);

  spi_state_e state_q, state_d;

  logic       tick;
  logic       gen_en;
  logic       edge_ev;
  logic       lead_edge;
  logic       sample_ev;
  logic       shift_ev;
  logic       accept;
  logic       frame_end;

  logic [1:0] mode_q;
  logic [4:0] edge_cnt_q;
  logic [7:0] tx_shift_q;
  logic [7:0] rx_shift_q;
  logic [7:0] rx_data_q;
  logic       sck_q;
  logic       ss_q;
  logic       mosi_q;
  logic       done_q;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (CLK),
    .rst  (RST),
    .en   (gen_en),
    .tick (tick)
  );

  // Edge n = edge_cnt_q + 1; odd n is the leading edge. The SETUP tick is edge 1.
  always_comb begin
    gen_en    = (state_q != ST_IDLE);
    accept    = (state_q == ST_IDLE) && START;
    edge_ev   = tick && ((state_q == ST_SETUP) || (state_q == ST_XFER));
    lead_edge = ~edge_cnt_q[0];
    sample_ev = edge_ev && (lead_edge != cpha_of(mode_q));
    shift_ev  = 1'b0;
    if (edge_ev) begin
      if (cpha_of(mode_q)) begin
        shift_ev = lead_edge;
      end else begin
        shift_ev = !lead_edge && (edge_cnt_q < LAST_SHIFT);
      end
    end
    frame_end = (state_q == ST_HOLD) && tick;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (START) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_XFER;
      ST_XFER:  if (tick && (edge_cnt_q == LAST_EDGE)) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_GAP;
      ST_GAP:   if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q     <= 2'b00;
      edge_cnt_q <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      sck_q      <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        mode_q     <= MODE;
        sck_q      <= cpol_of(MODE);
        ss_q       <= 1'b0;
        edge_cnt_q <= '0;
        rx_shift_q <= '0;
        // CPHA=0 must present the MSB before the first edge; CPHA=1 shifts it out on edge 1
        if (cpha_of(MODE)) begin
          mosi_q     <= 1'b0;
          tx_shift_q <= TX_DATA;
        end else begin
          mosi_q     <= TX_DATA[7];
          tx_shift_q <= {TX_DATA[6:0], 1'b0};
        end
      end
      if (edge_ev) begin
        sck_q      <= ~sck_q;
        edge_cnt_q <= edge_cnt_q + 5'd1;
      end
      if (sample_ev) begin
        rx_shift_q <= {rx_shift_q[6:0], MISO};
      end
      if (shift_ev) begin
        mosi_q     <= tx_shift_q[7];
        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
      end
      if (frame_end) begin
        ss_q      <= 1'b1;
        mosi_q    <= 1'b0;
        rx_data_q <= rx_shift_q;
        done_q    <= 1'b1;
      end
    end
  end

  assign RX_DATA = rx_data_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign DONE    = done_q;
  assign SCK     = sck_q;
  assign SS      = ss_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a mode-aware SPI slave model.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       busy, done, sck, ss, mosi;
  logic       miso = 1'b0;

  logic       start2 = 1'b0;
  logic [1:0] mode2 = 2'b00;
  logic [7:0] tx2 = 8'h00;
  logic       miso2 = 1'b1;
  logic [7:0] rx_data2;
  logic       busy2, done2, sck2, ss2, mosi2;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // slave model state
  logic [1:0] sl_mode = 2'b00;
  logic [7:0] sl_byte = 8'h00;
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic       sl_ss_prev = 1'b1;
  logic       sl_sck_prev = 1'b0;

  spi_master_ctrl #(.CLK_DIV(4)) dut (
    .CLK(clk), .RST(rst), .START(start), .MODE(mode), .TX_DATA(tx_data),
    .RX_DATA(rx_data), .BUSY(busy), .DONE(done), .SCK(sck), .SS(ss),
    .MOSI(mosi), .MISO(miso)
  );

  spi_master_ctrl #(.CLK_DIV(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .MODE(mode2), .TX_DATA(tx2),
    .RX_DATA(rx_data2), .BUSY(busy2), .DONE(done2), .SCK(sck2), .SS(ss2),
    .MOSI(mosi2), .MISO(miso2)
  );

  always #5 clk = ~clk;

  // Slave reacts half a clock after each master edge, so MISO is stable well before the next sample.
  always @(negedge clk) begin
    logic lead;
    if (sl_ss_prev === 1'b1 && ss === 1'b0) begin
      sl_tx = sl_byte;
      sl_rx = 8'h00;
      miso  = sl_mode[0] ? 1'b0 : sl_byte[7];
    end else if (ss === 1'b0 && sck !== sl_sck_prev) begin
      lead = (sck !== sl_mode[1]);
      if (lead == !sl_mode[0]) begin
        sl_rx = {sl_rx[6:0], mosi};
      end else if (sl_mode[0]) begin
        miso  = sl_tx[7];
        sl_tx = {sl_tx[6:0], 1'b0};
      end else begin
        sl_tx = {sl_tx[6:0], 1'b0};
        miso  = sl_tx[7];
      end
    end
    sl_sck_prev = sck;
    sl_ss_prev  = ss;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame on dut and reports what was observed, relative to the accepting edge k.
  task automatic run_frame(input logic [1:0] m, input logic [7:0] tx, input logic [7:0] sb,
                           output int done_at, output int done_cnt, output int busy_drop,
                           output int n_edges, output int first_e, output int last_e,
                           output logic start_ok, output logic mosi_k, output logic idle_ok,
                           output int ss_high, output logic rx_stable);
    logic [7:0] rx_prev;
    logic       prev_sck;
    done_at = -1; done_cnt = 0; busy_drop = -1; n_edges = 0; first_e = -1; last_e = -1;
    idle_ok = 1'b1; ss_high = 0; rx_stable = 1'b1;
    sl_mode = m; sl_byte = sb;
    mode = m; tx_data = tx; start = 1'b1;
    rx_prev = rx_data;
    tick();
    start = 1'b0; mode = ~m; tx_data = ~tx;
    start_ok = (busy === 1'b1) && (ss === 1'b0) && (sck === m[1]);
    mosi_k   = mosi;
    prev_sck = sck;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (sck !== prev_sck) begin
        n_edges++;
        if (first_e < 0) first_e = i;
        last_e = i;
      end
      prev_sck = sck;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (ss === 1'b1) begin
        ss_high++;
        if (sck !== m[1] || mosi !== 1'b0) idle_ok = 1'b0;
      end
      if (done_cnt == 0 && rx_data !== rx_prev) rx_stable = 1'b0;
      if (busy === 1'b0) begin
        busy_drop = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    chk_cnt++; if (ss !== 1'b1) $display("FAIL reset_ss: got %b expected 1", ss); else pass_cnt++;
    chk_cnt++; if (sck !== 1'b0) $display("FAIL reset_sck: got %b expected 0", sck); else pass_cnt++;
    chk_cnt++; if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b expected 0", mosi); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx: got %h expected 00", rx_data); else pass_cnt++;
  endtask

  task automatic test_mode0();
    int d_at, d_cnt, b_drop, n_e, f_e, l_e, ssh;
    logic s_ok, m_k, i_ok, r_st;
    run_frame(2'b00, 8'hBA, 8'hEF, d_at, d_cnt, b_drop, n_e, f_e, l_e, s_ok, m_k, i_ok, ssh, r_st);
    chk_cnt++; if (s_ok !== 1'b1) $display("FAIL m0_start_state: got %b expected 1", s_ok); else pass_cnt++;
    chk_cnt++; if (m_k !== 1'b1) $display("FAIL m0_mosi_at_k: got %b expected 1", m_k); else pass_cnt++;
    chk_cnt++; if (n_e != 16) $display("FAIL m0_sck_edges: got %0d expected 16", n_e); else pass_cnt++;
    chk_cnt++; if (f_e != 4) $display("FAIL m0_first_edge: got %0d expected 4", f_e); else pass_cnt++;
    chk_cnt++; if (l_e != 64) $display("FAIL m0_last_edge: got %0d expected 64", l_e); else pass_cnt++;
    chk_cnt++; if (d_at != 68) $display("FAIL m0_done_cycle: got %0d expected 68", d_at); else pass_cnt++;
    chk_cnt++; if (d_cnt != 1) $display("FAIL m0_done_count: got %0d expected 1", d_cnt); else pass_cnt++;
    chk_cnt++; if (b_drop != 72) $display("FAIL m0_busy_drop: got %0d expected 72", b_drop); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'hEF) $display("FAIL m0_rx_data: got %h expected ef", rx_data); else pass_cnt++;
    chk_cnt++; if (sl_rx !== 8'hBA) $display("FAIL m0_slave_rx: got %h expected ba", sl_rx); else pass_cnt++;
    chk_cnt++; if (i_ok !== 1'b1) $display("FAIL m0_idle_lines: got %b expected 1", i_ok); else pass_cnt++;
    chk_cnt++; if (r_st !== 1'b1) $display("FAIL m0_rx_stable: got %b expected 1", r_st); else pass_cnt++;
  endtask

  task automatic test_all_modes();
    logic [7:0] txv [4] = '{8'h0A, 8'hDA, 8'h1E, 8'h33};
    logic [7:0] sbv [4] = '{8'h33, 8'hF3, 8'h97, 8'hA5};
    int d_at, d_cnt, b_drop, n_e, f_e, l_e, ssh;
    logic s_ok, m_k, i_ok, r_st;
    for (int i = 0; i < 4; i++) begin
      run_frame(2'(i), txv[i], sbv[i], d_at, d_cnt, b_drop, n_e, f_e, l_e, s_ok, m_k, i_ok, ssh, r_st);
      chk_cnt++; if (s_ok !== 1'b1) $display("FAIL modes_start_state[%0d]: got %b expected 1", i, s_ok); else pass_cnt++;
      chk_cnt++; if (rx_data !== sbv[i]) $display("FAIL modes_rx[%0d]: got %h expected %h", i, rx_data, sbv[i]); else pass_cnt++;
      chk_cnt++; if (sl_rx !== txv[i]) $display("FAIL modes_slave_rx[%0d]: got %h expected %h", i, sl_rx, txv[i]); else pass_cnt++;
      chk_cnt++; if (i_ok !== 1'b1) $display("FAIL modes_idle_cpol[%0d]: got %b expected 1", i, i_ok); else pass_cnt++;
      chk_cnt++; if (ssh < 4) $display("FAIL modes_ss_gap[%0d]: got %0d expected >=4", i, ssh); else pass_cnt++;
      chk_cnt++; if (d_cnt != 1) $display("FAIL modes_done_count[%0d]: got %0d expected 1", i, d_cnt); else pass_cnt++;
      chk_cnt++; if (n_e != 16) $display("FAIL modes_sck_edges[%0d]: got %0d expected 16", i, n_e); else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored();
    int d_cnt = 0, d_at = -1, ss_falls = 0, b_drop = -1;
    logic ss_prev;
    sl_mode = 2'b00; sl_byte = 8'h3A;
    mode = 2'b00; tx_data = 8'h5C; start = 1'b1;
    tick();
    start = 1'b0;
    ss_prev = ss;
    for (int i = 1; i <= 150; i++) begin
      if (i == 20) start = 1'b1;
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        d_cnt++;
        if (d_at < 0) d_at = i;
      end
      if (ss_prev === 1'b1 && ss === 1'b0) ss_falls++;
      ss_prev = ss;
      if (busy === 1'b0 && b_drop < 0) b_drop = i;
    end
    chk_cnt++; if (d_cnt != 1) $display("FAIL ign_done_count: got %0d expected 1", d_cnt); else pass_cnt++;
    chk_cnt++; if (d_at != 68) $display("FAIL ign_done_cycle: got %0d expected 68", d_at); else pass_cnt++;
    chk_cnt++; if (ss_falls != 0) $display("FAIL ign_second_frame: got %0d expected 0", ss_falls); else pass_cnt++;
    chk_cnt++; if (b_drop != 72) $display("FAIL ign_busy_drop: got %0d expected 72", b_drop); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h3A) $display("FAIL ign_rx: got %h expected 3a", rx_data); else pass_cnt++;
    chk_cnt++; if (sl_rx !== 8'h5C) $display("FAIL ign_slave_rx: got %h expected 5c", sl_rx); else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    int d_cnt = 0, ss_low = 0;
    logic sck_before;
    sl_mode = 2'b01; sl_byte = 8'h11;
    mode = 2'b01; tx_data = 8'h77; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 29; i++) tick();
    sck_before = sck;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++; if (sck_before !== 1'b1) $display("FAIL rst_sck_before: got %b expected 1", sck_before); else pass_cnt++;
    chk_cnt++; if (ss !== 1'b1) $display("FAIL rst_mid_ss: got %b expected 1", ss); else pass_cnt++;
    chk_cnt++; if (sck !== 1'b0) $display("FAIL rst_mid_sck: got %b expected 0", sck); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL rst_mid_rx: got %h expected 00", rx_data); else pass_cnt++;
    chk_cnt++; if (mosi !== 1'b0) $display("FAIL rst_mid_mosi: got %b expected 0", mosi); else pass_cnt++;
    for (int i = 0; i < 80; i++) begin
      if (done === 1'b1) d_cnt++;
      if (ss === 1'b0) ss_low++;
      tick();
    end
    chk_cnt++; if (d_cnt != 0) $display("FAIL rst_mid_no_done: got %0d expected 0", d_cnt); else pass_cnt++;
    chk_cnt++; if (ss_low != 0) $display("FAIL rst_mid_ss_stays_high: got %0d expected 0", ss_low); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int d_pos [3] = '{-1, -1, -1};
    int d_cnt = 0, run = 0, max_run = 0, b_drop = -1;
    start2 = 1'b1;
    tick();
    for (int i = 1; i <= 115; i++) begin
      tick();
      if (done2 === 1'b1) begin
        if (d_cnt < 3) d_pos[d_cnt] = i;
        d_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    start2 = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (busy2 === 1'b0) begin
        b_drop = i;
        break;
      end
    end
    chk_cnt++; if (d_cnt != 3) $display("FAIL b2b_done_count: got %0d expected 3", d_cnt); else pass_cnt++;
    chk_cnt++; if (d_pos[0] != 34) $display("FAIL b2b_done0: got %0d expected 34", d_pos[0]); else pass_cnt++;
    chk_cnt++; if (d_pos[1] != 71) $display("FAIL b2b_done1: got %0d expected 71", d_pos[1]); else pass_cnt++;
    chk_cnt++; if (d_pos[2] != 108) $display("FAIL b2b_done2: got %0d expected 108", d_pos[2]); else pass_cnt++;
    chk_cnt++; if (max_run != 1) $display("FAIL b2b_done_width: got %0d expected 1", max_run); else pass_cnt++;
    chk_cnt++; if (rx_data2 !== 8'hFF) $display("FAIL b2b_rx: got %h expected ff", rx_data2); else pass_cnt++;
    chk_cnt++; if (b_drop < 0) $display("FAIL b2b_busy_timeout: got %0d expected >0", b_drop); else pass_cnt++;
    chk_cnt++; if (ss2 !== 1'b1 || mosi2 !== 1'b0 || sck2 !== 1'b0)
      $display("FAIL b2b_idle_lines: got ss=%b mosi=%b sck=%b expected 1/0/0", ss2, mosi2, sck2);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_mode0();
    test_all_modes();
    test_start_ignored();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
